// File: rtl/seven_seg_mux_ctrl.sv
// Time-multiplexed N-digit hex seven-segment driver with frame-synchronous digit
// updates and an anti-ghost blanking interval at the start of every digit slot.
module seven_seg_mux_ctrl #(
  parameter int NUM_DIGITS   = 2,
  parameter int REFRESH_DIV  = 24000,
  parameter int BLANK_CYCLES = 200,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    PH_BLANK,
    PH_DRIVE
  } phase_t;

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] pending;
  logic [4*NUM_DIGITS-1:0] shadow;
  phase_t                  phase;
  logic                    slot_end;
  logic                    frame_end;
  logic [3:0]              nibble;
  logic                    cur_en;
  logic [NUM_DIGITS-1:0]   sel;
  logic [6:0]              seg_on;
  logic [NUM_DIGITS-1:0]   an_on;

  // Segment patterns {g,f,e,d,c,b,a} in the board's native active-low form.
  function automatic logic [6:0] decode_low(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'h0: p = 7'b1000000;
      4'h1: p = 7'b1111001;
      4'h2: p = 7'b0100100;
      4'h3: p = 7'b0110000;
      4'h4: p = 7'b0011001;
      4'h5: p = 7'b0010010;
      4'h6: p = 7'b0000010;
      4'h7: p = 7'b1111000;
      4'h8: p = 7'b0000000;
      4'h9: p = 7'b0010000;
      4'hA: p = 7'b0001000;
      4'hB: p = 7'b0000011;
      4'hC: p = 7'b1000110;
      4'hD: p = 7'b0100001;
      4'hE: p = 7'b0000110;
      default: p = 7'b0001110;
    endcase
    return p;
  endfunction

  always_comb begin
    slot_end  = (cnt == CNT_LAST);
    frame_end = slot_end && (idx == IDX_LAST);
    phase     = (cnt < BLANK_END) ? PH_BLANK : PH_DRIVE;
    nibble    = 4'h0;
    cur_en    = 1'b0;
    sel       = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        nibble = shadow[4*k +: 4];
        cur_en = digit_en[k];
        sel[k] = 1'b1;
      end
    end
    // Polarity-neutral "lit" vectors; a disabled digit stays dark but keeps its slot.
    seg_on = '0;
    an_on  = '0;
    if (phase == PH_DRIVE && cur_en) begin
      seg_on = ~decode_low(nibble);
      an_on  = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      pending    <= '0;
      shadow     <= '0;
      seg        <= {7{ACTIVE_LOW}};
      an         <= {NUM_DIGITS{ACTIVE_LOW}};
      frame_done <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (load) pending <= digits_in;
      // Shadow only moves at the frame boundary so a frame never tears.
      if (frame_end) shadow <= load ? digits_in : pending;
      seg        <= ACTIVE_LOW ? ~seg_on : seg_on;
      an         <= ACTIVE_LOW ? ~an_on : an_on;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux_ctrl.sv
// Scoreboard bench: a frame-position reference model predicts each cycle's outputs for
// an active-low and an active-high instance; a separate monitor pops and compares them.
module tb_seven_seg_mux_ctrl;

  localparam int ND    = 2;
  localparam int RD    = 8;
  localparam int BL    = 2;
  localparam int TOTAL = ND * RD;

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] an;
    logic       fd;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] digits_in;
  logic [1:0] digit_en;
  logic [6:0] seg_l, seg_h;
  logic [1:0] an_l, an_h;
  logic       fd_l, fd_h;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;

  int m_t    = 0;
  int m_pend = 0;
  int m_shad = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seven_seg_mux_ctrl #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BL), .ACTIVE_LOW(1'b1)
  ) dut_low (
    .clk(clk), .reset(reset), .digits_in(digits_in), .load(load),
    .digit_en(digit_en), .seg(seg_l), .an(an_l), .frame_done(fd_l)
  );

  seven_seg_mux_ctrl #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BL), .ACTIVE_LOW(1'b0)
  ) dut_high (
    .clk(clk), .reset(reset), .digits_in(digits_in), .load(load),
    .digit_en(digit_en), .seg(seg_h), .an(an_h), .frame_done(fd_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, expv, cycle);
    end
  endtask

  // Drive one cycle of inputs, predict the registered response and advance the model.
  task automatic applyStimulus(input logic rst, input logic ld, input logic [7:0] din,
                               input logic [1:0] en);
    exp_t e;
    int   slot, off, dig;
    reset     = rst;
    load      = ld;
    digits_in = din;
    digit_en  = en;
    e.seg = 7'h7F;
    e.an  = 2'b11;
    e.fd  = 1'b0;
    if (rst) begin
      m_t    = 0;
      m_pend = 0;
      m_shad = 0;
    end else begin
      slot = m_t / RD;
      off  = m_t % RD;
      dig  = (m_shad >> (4 * slot)) & 15;
      e.fd = (m_t == TOTAL - 1);
      if (off >= BL && en[slot]) begin
        e.seg      = seg_tab[dig];
        e.an[slot] = 1'b0;
      end
      if (m_t == TOTAL - 1) m_shad = ld ? int'(din) : m_pend;
      if (ld) m_pend = int'(din);
      m_t = (m_t + 1) % TOTAL;
    end
    sb.push_back(e);
    @(negedge clk);
    cycle++;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [6:0] seg_hi;
    logic [1:0] an_hi;
    seg_hi = ~e.seg;
    an_hi  = ~e.an;
    compare("seg_low", 32'(seg_l), 32'(e.seg));
    compare("an_low", 32'(an_l), 32'(e.an));
    compare("frame_done_low", 32'(fd_l), 32'(e.fd));
    compare("seg_high", 32'(seg_h), 32'(seg_hi));
    compare("an_high", 32'(an_h), 32'(an_hi));
    compare("frame_done_high", 32'(fd_h), 32'(e.fd));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  initial begin
    reset     = 1'b1;
    load      = 1'b0;
    digits_in = 8'h00;
    digit_en  = 2'b11;
    @(negedge clk);
    repeat (5) applyStimulus(1'b1, 1'b0, 8'h00, 2'b11);
    repeat (36) applyStimulus(1'b0, 1'b0, 8'h00, 2'b11);
    applyStimulus(1'b0, 1'b1, 8'hA1, 2'b11);
    while (m_t != TOTAL - 1) applyStimulus(1'b0, 1'b0, 8'h00, 2'b11);
    repeat (TOTAL) applyStimulus(1'b0, 1'b0, 8'h00, 2'b11);
    while (m_t != TOTAL - 1) applyStimulus(1'b0, 1'b0, 8'h00, 2'b11);
    applyStimulus(1'b0, 1'b1, 8'h8F, 2'b11);
    repeat (2 * TOTAL) applyStimulus(1'b0, 1'b0, 8'h00, 2'b11);
    repeat (3 * TOTAL) applyStimulus(1'b0, 1'b0, 8'h00, 2'b01);
    // Abort the scan at cnt=5 of slot 1, then confirm it restarts from digit 0.
    while (m_t != RD + 5) applyStimulus(1'b0, 1'b0, 8'h00, 2'b11);
    repeat (2) applyStimulus(1'b1, 1'b0, 8'h00, 2'b11);
    repeat (2 * TOTAL) applyStimulus(1'b0, 1'b0, 8'h00, 2'b11);
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0),
                    8'($urandom), 2'($urandom));
    end
    repeat (3) @(negedge clk);
    compare("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
